// File: rtl/nzr_bit_decoder.sv
// nzr_bit_decoder: samples the NZR line, classifies high pulses by width into bits,
// assembles 24-bit GRB words and flags frame ends after a long low run.
module nzr_bit_decoder #(
    parameter int MIN_HIGH   = 8,
    parameter int BIT_THRESH = 30,
    parameter int MAX_HIGH   = 100,
    parameter int RESET_CYC  = 2500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dataIn,
    output logic [23:0] pixel,
    output logic        pixelValid,
    output logic [7:0]  pixelIdx,
    output logic        frameDone,
    output logic [7:0]  frameLen,
    output logic        bitErr
);
    localparam int CW = $clog2((MAX_HIGH > RESET_CYC ? MAX_HIGH : RESET_CYC) + 1);
    localparam logic [CW-1:0] MIN_W     = CW'(MIN_HIGH);
    localparam logic [CW-1:0] THRESH    = CW'(BIT_THRESH);
    localparam logic [CW-1:0] HIGH_LAST = CW'(MAX_HIGH - 1);
    localparam logic [CW-1:0] LOW_LAST  = CW'(RESET_CYC - 1);
    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;
    state_t state, stateNext;
    logic sync1, dS, dP, rise;
    logic [CW-1:0] lowCnt, lowCntNext, highCnt, highCntNext;
    logic [4:0] bitCnt, bitCntNext;
    logic [23:0] word, wordNext, pixelNext, shifted;
    logic [7:0] pixCnt, pixCntNext, pixelIdxNext, frameLenNext;
    logic pixelValidNext, frameDoneNext, bitErrNext;
    assign rise = dS & ~dP;
    assign shifted = {word[22:0], highCnt >= THRESH};
    always_ff @(posedge clk) begin
        if (reset) begin
            {sync1, dS, dP} <= '0;
            state <= SYNC;
            lowCnt <= '0;
            highCnt <= '0;
            bitCnt <= '0;
            word <= '0;
            pixCnt <= '0;
            pixel <= '0;
            pixelIdx <= '0;
            frameLen <= '0;
            pixelValid <= 1'b0;
            frameDone <= 1'b0;
            bitErr <= 1'b0;
        end else begin
            sync1 <= dataIn;
            dS <= sync1;
            dP <= dS;
            state <= stateNext;
            lowCnt <= lowCntNext;
            highCnt <= highCntNext;
            bitCnt <= bitCntNext;
            word <= wordNext;
            pixCnt <= pixCntNext;
            pixel <= pixelNext;
            pixelIdx <= pixelIdxNext;
            frameLen <= frameLenNext;
            pixelValid <= pixelValidNext;
            frameDone <= frameDoneNext;
            bitErr <= bitErrNext;
        end
    end
    always_comb begin
        stateNext = state;
        lowCntNext = lowCnt;
        highCntNext = highCnt;
        bitCntNext = bitCnt;
        wordNext = word;
        pixCntNext = pixCnt;
        pixelNext = pixel;
        pixelIdxNext = pixelIdx;
        frameLenNext = frameLen;
        pixelValidNext = 1'b0;
        frameDoneNext = 1'b0;
        bitErrNext = 1'b0;
        case (state)
            SYNC: begin
                lowCntNext = dS ? '0 : lowCnt + 1'b1;
                stateNext = (!dS && lowCnt >= LOW_LAST) ? IDLE : SYNC;
            end
            IDLE: if (rise) begin
                stateNext = HIGH;
                highCntNext = CW'(1);
            end
            HIGH: if (dS) begin
                if (highCnt >= HIGH_LAST) begin
                    bitErrNext = 1'b1;
                    bitCntNext = '0;
                    wordNext = '0;
                    pixCntNext = '0;
                    pixelIdxNext = '0;
                    lowCntNext = '0;
                    stateNext = SYNC;
                end else highCntNext = highCnt + 1'b1;
            end else begin
                stateNext = LOW;
                lowCntNext = CW'(1);
                // completing the 24th bit publishes the word directly, keeping latency at 3 edges
                if (highCnt < MIN_W) bitErrNext = 1'b1;
                else if (bitCnt == 5'd23) begin
                    pixelNext = shifted;
                    pixelValidNext = 1'b1;
                    pixelIdxNext = pixCnt;
                    pixCntNext = pixCnt + {7'd0, pixCnt != 8'hFF};
                    bitCntNext = '0;
                    wordNext = '0;
                end else begin
                    wordNext = shifted;
                    bitCntNext = bitCnt + 1'b1;
                end
            end
            LOW: if (rise) begin
                stateNext = HIGH;
                highCntNext = CW'(1);
            end else if (lowCnt >= LOW_LAST) begin
                frameDoneNext = 1'b1;
                frameLenNext = pixCnt;
                bitErrNext = bitCnt != 5'd0;
                bitCntNext = '0;
                pixCntNext = '0;
                wordNext = '0;
                stateNext = IDLE;
            end else lowCntNext = lowCnt + 1'b1;
            default: stateNext = SYNC;
        endcase
    end
endmodule

// File: tb/tb_nzr_bit_decoder.sv
// tb_nzr_bit_decoder: randomized pulse-width stimulus compared against a segment-level
// model of the decoder that predicts the ordered stream of pixel/frame/error events.
module tb_nzr_bit_decoder;
    localparam int MIN_HIGH = 8, BIT_THRESH = 30, MAX_HIGH = 100, RESET_CYC = 2500;
    localparam int K_PIX = 1, K_FRAME = 2, K_ERR = 3, K_FRAME_ERR = 4;
    typedef struct {
        int kind;
        logic [31:0] data;
    } ev_t;
    logic clk = 1'b0, reset = 1'b1, dataIn = 1'b0;
    logic [23:0] pixel;
    logic pixelValid, frameDone, bitErr;
    logic [7:0] pixelIdx, frameLen;
    ev_t gotQ[$], expQ[$];
    int checks = 0, errors = 0, cyc = 0, pvCyc = -1;
    bit mSynced, mStarted;
    int mLowRun, mBits, mPix;
    logic [23:0] mWord;

    nzr_bit_decoder dut (
        .clk(clk), .reset(reset), .dataIn(dataIn), .pixel(pixel), .pixelValid(pixelValid),
        .pixelIdx(pixelIdx), .frameDone(frameDone), .frameLen(frameLen), .bitErr(bitErr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mkEv(input int k, input logic [31:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        return e;
    endfunction

    always @(negedge clk) begin
        if (pixelValid) begin
            gotQ.push_back(mkEv(K_PIX, {pixelIdx, pixel}));
            pvCyc = cyc;
        end
        if (frameDone) gotQ.push_back(mkEv(bitErr ? K_FRAME_ERR : K_FRAME, {24'd0, frameLen}));
        else if (bitErr) gotQ.push_back(mkEv(K_ERR, 32'd0));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // line-level model: each constant-level segment of n cycles updates the expectation
    task automatic modelSeg(input logic v, input int n);
        if (v) begin
            mLowRun = 0;
            if (!mSynced) return;
            mStarted = 1;
            if (n >= MAX_HIGH) begin
                expQ.push_back(mkEv(K_ERR, 32'd0));
                mSynced = 0;
                mStarted = 0;
                mBits = 0;
                mPix = 0;
                mWord = '0;
            end else if (n < MIN_HIGH) expQ.push_back(mkEv(K_ERR, 32'd0));
            else begin
                mWord = {mWord[22:0], n >= BIT_THRESH};
                mBits++;
                if (mBits == 24) begin
                    expQ.push_back(mkEv(K_PIX, {mPix[7:0], mWord}));
                    mPix = (mPix == 255) ? 255 : mPix + 1;
                    mBits = 0;
                end
            end
        end else begin
            if (!mSynced) begin
                if (mLowRun + n >= RESET_CYC) mSynced = 1;
            end else if (mStarted && mLowRun < RESET_CYC && mLowRun + n >= RESET_CYC) begin
                expQ.push_back(mkEv(mBits != 0 ? K_FRAME_ERR : K_FRAME, {24'd0, mPix[7:0]}));
                mBits = 0;
                mPix = 0;
                mStarted = 0;
            end
            mLowRun += n;
        end
    endtask

    task automatic drive(input logic v, input int n);
        dataIn = v;
        repeat (n) @(negedge clk);
        modelSeg(v, n);
    endtask

    task automatic sendBit(input logic b);
        int hi;
        hi = (b ? 40 : 20) + int'($urandom_range(2)) - 1;
        drive(1'b1, hi);
        drive(1'b0, 62 - hi + int'($urandom_range(4)));
    endtask

    task automatic sendWord(input logic [23:0] w, input int glitchAt);
        for (int i = 23; i >= 0; i--) begin
            if (i == glitchAt) begin
                drive(1'b1, 3);
                drive(1'b0, 20);
            end
            sendBit(w[i]);
        end
    endtask

    task automatic compareEvents(input string tag);
        drive(1'b0, 5);
        check({tag, ".count"}, gotQ.size(), expQ.size());
        for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
            check({tag, ".kind"}, gotQ[i].kind, expQ[i].kind);
            check({tag, ".data"}, gotQ[i].data, expQ[i].data);
        end
        gotQ.delete();
        expQ.delete();
    endtask

    task automatic doReset();
        reset = 1'b1;
        dataIn = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        mSynced = 0;
        mStarted = 0;
        mLowRun = 0;
        mBits = 0;
        mPix = 0;
        mWord = '0;
    endtask

    task automatic checkCleared(input string tag);
        check({tag, ".pixel"}, pixel, 24'd0);
        check({tag, ".pixelValid"}, pixelValid, 1'b0);
        check({tag, ".pixelIdx"}, pixelIdx, 8'd0);
        check({tag, ".frameDone"}, frameDone, 1'b0);
        check({tag, ".frameLen"}, frameLen, 8'd0);
        check({tag, ".bitErr"}, bitErr, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int fallCyc;
        logic [23:0] w;
        @(negedge clk);
        doReset();
        checkCleared("reset");
        drive(1'b0, RESET_CYC);
        w = 24'hFF0000;
        for (int i = 23; i >= 1; i--) sendBit(w[i]);
        drive(1'b1, 20);
        fallCyc = cyc;
        drive(1'b0, 42);
        check("latency", pvCyc - fallCyc, 3);
        drive(1'b0, RESET_CYC);
        compareEvents("single");

        sendWord(24'h123456, -1);
        sendWord(24'hABCDEF, -1);
        sendWord(24'h000001, -1);
        drive(1'b0, RESET_CYC);
        compareEvents("three");

        sendWord(24'h5A5A5A, 12);
        drive(1'b0, RESET_CYC);
        compareEvents("glitch");

        for (int i = 0; i < 10; i++) sendBit(1'($urandom_range(1)));
        drive(1'b0, RESET_CYC);
        compareEvents("partial");

        drive(1'b1, 150);
        drive(1'b0, 30);
        sendWord(24'($urandom), -1);
        drive(1'b0, RESET_CYC + 50);
        sendWord(24'($urandom), -1);
        drive(1'b0, RESET_CYC);
        compareEvents("stuck");

        doReset();
        for (int i = 0; i < 10; i++) sendBit(1'($urandom_range(1)));
        sendWord(24'($urandom), -1);
        drive(1'b0, RESET_CYC + 100);
        sendWord(24'($urandom), -1);
        drive(1'b0, RESET_CYC);
        compareEvents("midstart");

        doReset();
        drive(1'b0, RESET_CYC + 10);
        sendWord(24'($urandom_range(24'hFFFFFF, 1)), -1);
        for (int i = 0; i < 12; i++) sendBit(1'($urandom_range(1)));
        compareEvents("preReset");
        doReset();
        checkCleared("midReset");
        drive(1'b0, RESET_CYC + 10);
        sendWord(24'($urandom), -1);
        drive(1'b0, RESET_CYC);
        compareEvents("resync");

        for (int f = 0; f < 2; f++) begin
            int nw;
            nw = int'($urandom_range(2, 1));
            for (int k = 0; k < nw; k++) sendWord(24'($urandom), ($urandom_range(3) == 0) ? int'($urandom_range(22)) : -1);
            drive(1'b0, RESET_CYC + int'($urandom_range(40)));
            compareEvents("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
